fila_arbiter: RTL and testbench

//  Shares one 8-entry fila (queue) between N_REQ enqueue requesters and one dequeue consumer.

---
 rtl/fila_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_fila_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fila_arbiter.sv
// Round-robin arbiter sharing one fila queue between N_REQ enqueue ports and one dequeue consumer.
// Optional FILA_ARB_STATS_EN adds enq_count/deq_count operation counters.
//
// state       | meaning
// IDLE        | search slots from rr_ptr, grant first eligible
// ENQ_ISSUE   | q_enqueue high, fila samples the request
// ENQ_WAIT    | fila writes q_data, enq_ack pulses
// DEQ_ISSUE   | q_dequeue high, fila samples the request
// DEQ_WAIT    | fila pops into its data_out register
// DEQ_CAPTURE | latch q_data_out into deq_data, raise deq_valid
module fila_arbiter #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock_10KHz,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         enq_req,
    input  logic [N_REQ*WIDTH-1:0]   enq_data,
    output logic [N_REQ-1:0]         enq_ack,
    input  logic                     deq_req,
    output logic                     deq_valid,
    output logic [WIDTH-1:0]         deq_data,
    output logic                     q_enqueue,
    output logic                     q_dequeue,
    output logic [WIDTH-1:0]         q_data,
    input  logic [7:0]               q_len,
    input  logic [WIDTH-1:0]         q_data_out
`ifdef FILA_ARB_STATS_EN
    ,
    output logic [15:0]              enq_count,
    output logic [15:0]              deq_count
`endif
);

    localparam int NS = N_REQ + 1;
    localparam int PW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ENQ_ISSUE   = 3'd1,
        ENQ_WAIT    = 3'd2,
        DEQ_ISSUE   = 3'd3,
        DEQ_WAIT    = 3'd4,
        DEQ_CAPTURE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic [PW-1:0]      gnt_q, gnt_d;
    logic [N_REQ-1:0]   enq_ack_q, enq_ack_d;
    logic               deq_valid_q, deq_valid_d;
    logic [WIDTH-1:0]   deq_data_q, deq_data_d;
    logic               q_enqueue_q, q_enqueue_d;
    logic               q_dequeue_q, q_dequeue_d;
    logic [WIDTH-1:0]   q_data_q, q_data_d;

    logic [NS-1:0]      elig;
    logic               found;
    logic [PW-1:0]      win;
    logic [PW-1:0]      idx;

    // Slot N_REQ is the dequeue port; enqueue slots are masked while fila is full.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = enq_req[i] && (q_len < 8'(DEPTH));
        end
        elig[N_REQ] = deq_req && (q_len != 8'd0);
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NS; k++) begin
            idx = PW'((int'(rr_q) + k) % NS);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        q_data_d    = q_data_q;
        deq_data_d  = deq_data_q;
        q_enqueue_d = 1'b0;
        q_dequeue_d = 1'b0;
        enq_ack_d   = '0;
        deq_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    rr_d  = (win == PW'(N_REQ)) ? '0 : win + 1'b1;
                    gnt_d = win;
                    if (win == PW'(N_REQ)) begin
                        q_dequeue_d = 1'b1;
                        state_d     = DEQ_ISSUE;
                    end else begin
                        q_data_d    = enq_data[int'(win)*WIDTH +: WIDTH];
                        q_enqueue_d = 1'b1;
                        state_d     = ENQ_ISSUE;
                    end
                end
            end
            ENQ_ISSUE: begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (gnt_q == PW'(i)) enq_ack_d[i] = 1'b1;
                end
                state_d = ENQ_WAIT;
            end
            ENQ_WAIT:  state_d = IDLE;
            DEQ_ISSUE: state_d = DEQ_WAIT;
            DEQ_WAIT:  state_d = DEQ_CAPTURE;
            DEQ_CAPTURE: begin
                deq_data_d  = q_data_out;
                deq_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_10KHz) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            gnt_q       <= '0;
            enq_ack_q   <= '0;
            deq_valid_q <= 1'b0;
            deq_data_q  <= '0;
            q_enqueue_q <= 1'b0;
            q_dequeue_q <= 1'b0;
            q_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            enq_ack_q   <= enq_ack_d;
            deq_valid_q <= deq_valid_d;
            deq_data_q  <= deq_data_d;
            q_enqueue_q <= q_enqueue_d;
            q_dequeue_q <= q_dequeue_d;
            q_data_q    <= q_data_d;
        end
    end

    assign enq_ack   = enq_ack_q;
    assign deq_valid = deq_valid_q;
    assign deq_data  = deq_data_q;
    assign q_enqueue = q_enqueue_q;
    assign q_dequeue = q_dequeue_q;
    assign q_data    = q_data_q;

`ifdef FILA_ARB_STATS_EN
    logic [15:0] enq_count_q, enq_count_d;
    logic [15:0] deq_count_q, deq_count_d;

    // Counters follow the visible pulses, so they lag the pulse by one cycle.
    always_comb begin
        enq_count_d = enq_count_q;
        deq_count_d = deq_count_q;
        if (|enq_ack_q) enq_count_d = enq_count_q + 16'd1;
        if (deq_valid_q) deq_count_d = deq_count_q + 16'd1;
    end

    always_ff @(posedge clock_10KHz) begin
        if (!reset) begin
            enq_count_q <= '0;
            deq_count_q <= '0;
        end else begin
            enq_count_q <= enq_count_d;
            deq_count_q <= deq_count_d;
        end
    end

    assign enq_count = enq_count_q;
    assign deq_count = deq_count_q;
`endif

endmodule

// File: tb/tb_fila_arbiter.sv
// Directed bench for fila_arbiter with a behavioural fila model (delayed write, registered data_out).
// Stats ports are connected and checked only when FILA_ARB_STATS_EN is defined.
module tb_fila_arbiter;

    localparam int N = 2;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   enq_req;
    logic [N*W-1:0] enq_data;
    logic [N-1:0]   enq_ack;
    logic           deq_req;
    logic           deq_valid;
    logic [W-1:0]   deq_data;
    logic           q_enqueue;
    logic           q_dequeue;
    logic [W-1:0]   q_data;
    logic [7:0]     q_len;
    logic [W-1:0]   q_data_out;
`ifdef FILA_ARB_STATS_EN
    logic [15:0]    enq_count;
    logic [15:0]    deq_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fila_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(8)) dut (
        .clock_10KHz (clk),
        .reset       (reset),
        .enq_req     (enq_req),
        .enq_data    (enq_data),
        .enq_ack     (enq_ack),
        .deq_req     (deq_req),
        .deq_valid   (deq_valid),
        .deq_data    (deq_data),
        .q_enqueue   (q_enqueue),
        .q_dequeue   (q_dequeue),
        .q_data      (q_data),
        .q_len       (q_len),
        .q_data_out  (q_data_out)
`ifdef FILA_ARB_STATS_EN
        ,
        .enq_count   (enq_count),
        .deq_count   (deq_count)
`endif
    );

    // fila model: samples the pulse, acts one cycle later; reset is ~reset at top level
    logic [W-1:0] mem [8];
    logic [2:0]   head, tail;
    logic         enq_p, deq_p;

    always @(posedge clk) begin
        if (!reset) begin
            head <= 3'd0; tail <= 3'd0; q_len <= 8'd0; q_data_out <= '0;
            enq_p <= 1'b0; deq_p <= 1'b0;
        end else begin
            enq_p <= q_enqueue;
            deq_p <= q_dequeue;
            if (enq_p && q_len < 8'd8) begin
                mem[tail] <= q_data;
                tail      <= tail + 3'd1;
                q_len     <= q_len + 8'd1;
            end
            if (deq_p && q_len != 8'd0) begin
                q_data_out <= mem[head];
                head       <= head + 3'd1;
                q_len      <= q_len - 8'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic prev_enq = 1'b0;
    logic prev_deq = 1'b0;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("enq_deq_overlap", {31'd0, q_enqueue & q_dequeue}, 32'd0);
            check("enq_back_to_back", {31'd0, q_enqueue & prev_enq}, 32'd0);
            check("deq_back_to_back", {31'd0, q_dequeue & prev_deq}, 32'd0);
            prev_enq = q_enqueue;
            prev_deq = q_dequeue;
        end else begin
            prev_enq = 1'b0;
            prev_deq = 1'b0;
        end
    end

    task automatic do_enq(input int p, input logic [W-1:0] d);
        logic seen;
        seen = 1'b0;
        enq_data[p*W +: W] = d;
        enq_req[p] = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (enq_ack[p]) seen = 1'b1;
        end
        enq_req[p] = 1'b0;
        check("enq_ack_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic do_deq(input logic [W-1:0] exp, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        deq_req = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            lat++;
            if (deq_valid) seen = 1'b1;
        end
        deq_req = 1'b0;
        check("deq_valid_seen", {31'd0, seen}, 32'd1);
        check("deq_data", {24'd0, deq_data}, {24'd0, exp});
    endtask

    int            lat;
    int            n;
    logic [N-1:0]  acks [4];
    logic          any_q;
    logic          seen_v;

    initial begin
        reset = 1'b0; enq_req = '0; enq_data = '0; deq_req = 1'b0;
        #20000000 $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        tick(); tick();
        check("rst_enq_ack", {30'd0, enq_ack}, 32'd0);
        check("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        check("rst_deq_data", {24'd0, deq_data}, 32'd0);
        check("rst_q_enqueue", {31'd0, q_enqueue}, 32'd0);
        check("rst_q_dequeue", {31'd0, q_dequeue}, 32'd0);
        check("rst_q_data", {24'd0, q_data}, 32'd0);
`ifdef FILA_ARB_STATS_EN
        check("rst_enq_count", {16'd0, enq_count}, 32'd0);
        check("rst_deq_count", {16'd0, deq_count}, 32'd0);
`endif
        reset = 1'b1;
        any_q = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_q = any_q | q_enqueue | q_dequeue;
        end
        check("idle_no_ops", {31'd0, any_q}, 32'd0);

        // single enqueue of A5, cycle-exact
        enq_data[7:0] = 8'hA5;
        enq_req = 2'b01;
        tick();
        check("a5_t1_q_enqueue", {31'd0, q_enqueue}, 32'd1);
        check("a5_t1_q_data", {24'd0, q_data}, 32'hA5);
        check("a5_t1_ack", {30'd0, enq_ack}, 32'd0);
        tick();
        check("a5_t2_q_enqueue", {31'd0, q_enqueue}, 32'd0);
        check("a5_t2_q_data", {24'd0, q_data}, 32'hA5);
        check("a5_t2_ack", {30'd0, enq_ack}, 32'd1);
        enq_req = 2'b00;
        tick();
        check("a5_t3_ack", {30'd0, enq_ack}, 32'd0);
        check("a5_q_len", {24'd0, q_len}, 32'd1);

        do_deq(8'hA5, lat);
        check("deq_latency", lat, 32'd4);
        tick();
        check("a5_drained_len", {24'd0, q_len}, 32'd0);

        // two requesters held: round-robin 0,1,0,1
        enq_data = {8'h22, 8'h11};
        enq_req = 2'b11;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick();
            if (enq_ack != '0) begin
                acks[n] = enq_ack;
                n++;
                if (n == 4) enq_req = 2'b00;
            end
        end
        check("rr_ack_count", n, 32'd4);
        check("rr_ack0", {30'd0, acks[0]}, 32'd1);
        check("rr_ack1", {30'd0, acks[1]}, 32'd2);
        check("rr_ack2", {30'd0, acks[2]}, 32'd1);
        check("rr_ack3", {30'd0, acks[3]}, 32'd2);
        do_deq(8'h11, lat);
        do_deq(8'h22, lat);
        do_deq(8'h11, lat);
        do_deq(8'h22, lat);
        tick();
        check("rr_drained_len", {24'd0, q_len}, 32'd0);

        // fill to full, pending enqueue must wait until a dequeue frees a slot
        do_enq(0, 8'h11);
        for (int i = 1; i < 8; i++) do_enq(0, 8'(8'h30 + i));
        tick();
        check("full_len", {24'd0, q_len}, 32'd8);
        enq_data[7:0] = 8'h77;
        enq_req = 2'b01;
        any_q = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            any_q = any_q | q_enqueue;
        end
        check("full_no_enqueue", {31'd0, any_q}, 32'd0);
        do_deq(8'h11, lat);
        seen_v = 1'b0;
        for (int i = 0; i < 20 && !seen_v; i++) begin
            tick();
            if (enq_ack[0]) seen_v = 1'b1;
        end
        enq_req = 2'b00;
        check("full_pending_ack", {31'd0, seen_v}, 32'd1);
        tick();
        check("full_len_again", {24'd0, q_len}, 32'd8);
        for (int i = 1; i < 8; i++) do_deq(8'(8'h30 + i), lat);
        do_deq(8'h77, lat);
        tick();
        check("full_drained_len", {24'd0, q_len}, 32'd0);

        // empty: dequeue must wait, then an enqueue releases it
        deq_req = 1'b1;
        any_q = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_q = any_q | q_dequeue;
        end
        check("empty_no_dequeue", {31'd0, any_q}, 32'd0);
        do_enq(1, 8'h5A);
        seen_v = 1'b0;
        for (int i = 0; i < 20 && !seen_v; i++) begin
            tick();
            if (deq_valid) seen_v = 1'b1;
        end
        deq_req = 1'b0;
        check("empty_deq_valid", {31'd0, seen_v}, 32'd1);
        check("empty_deq_data", {24'd0, deq_data}, 32'h5A);
        tick();
        check("empty_len", {24'd0, q_len}, 32'd0);
        check("deq_data_held", {24'd0, deq_data}, 32'h5A);

        // reset while in ENQ_WAIT
        enq_data[7:0] = 8'h99;
        enq_req = 2'b01;
        tick();
        tick();
        check("mid_rst_pre_ack", {30'd0, enq_ack}, 32'd1);
        reset = 1'b0;
        enq_req = 2'b00;
        tick();
        check("mid_rst_ack", {30'd0, enq_ack}, 32'd0);
        check("mid_rst_q_enqueue", {31'd0, q_enqueue}, 32'd0);
        check("mid_rst_q_data", {24'd0, q_data}, 32'd0);
        check("mid_rst_deq_data", {24'd0, deq_data}, 32'd0);
        check("mid_rst_len", {24'd0, q_len}, 32'd0);
`ifdef FILA_ARB_STATS_EN
        check("mid_rst_enq_count", {16'd0, enq_count}, 32'd0);
        check("mid_rst_deq_count", {16'd0, deq_count}, 32'd0);
`endif
        reset = 1'b1;
        any_q = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            any_q = any_q | q_enqueue | q_dequeue | (|enq_ack);
        end
        check("post_rst_quiet", {31'd0, any_q}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
